// File: rtl/clb_cfg_loader.sv
`timescale 1ns/1ps
// Serial CLB configuration loader: sliding preamble sync, LSB-first payload, even parity, stop bit.
// Latency: CFG/CFG_VALID update on the stop-bit edge (visible the following cycle).
// Backpressure: none; DVALID=0 edges hold all state, ABORT drops the frame silently.
module clb_cfg_loader #(
    parameter int               CFG_W     = 37,
    parameter logic [CFG_W-1:0] CFG_RESET = 37'h1_50E0_0116,
    parameter logic [3:0]       PREAMBLE  = 4'b0010
) (
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DVALID,
    input  logic             ABORT,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VALID,
    output logic             CFG_ERR,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(CFG_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PAR, STOP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         window, window_nxt;
    logic [3:0]         win_shift;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CFG_W-1:0]   shadow, shadow_nxt;
    logic               parity, parity_nxt;
    logic [CFG_W-1:0]   cfg_q, cfg_nxt;
    logic               cfg_vld_q, cfg_vld_nxt;
    logic               cfg_err_q, cfg_err_nxt;
    logic               done_q, done_nxt;

    assign win_shift = {window[2:0], DIN};

    always_comb begin
        state_nxt   = state;
        window_nxt  = window;
        cnt_nxt     = cnt;
        shadow_nxt  = shadow;
        parity_nxt  = parity;
        cfg_nxt     = cfg_q;
        cfg_vld_nxt = 1'b0;
        cfg_err_nxt = 1'b0;
        done_nxt    = done_q;

        if (ABORT) begin
            state_nxt  = IDLE;
            window_nxt = 4'b1111;
        end else if (DVALID) begin
            case (state)
                IDLE: begin
                    window_nxt = win_shift;
                    if (win_shift == PREAMBLE) begin
                        state_nxt  = LOAD;
                        cnt_nxt    = '0;
                        window_nxt = 4'b1111;
                        parity_nxt = 1'b0;
                    end
                end
                LOAD: begin
                    // Payload is never searched for the preamble; it is plain data.
                    shadow_nxt[cnt] = DIN;
                    parity_nxt      = parity ^ DIN;
                    if (cnt == CNT_LAST) begin
                        state_nxt = PAR;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PAR: begin
                    parity_nxt = parity ^ DIN;
                    state_nxt  = STOP;
                end
                STOP: begin
                    if (DIN && !parity) begin
                        cfg_nxt     = shadow;
                        cfg_vld_nxt = 1'b1;
                        done_nxt    = 1'b1;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge K) begin
        if (RST) begin
            state     <= IDLE;
            window    <= 4'b1111;
            cnt       <= '0;
            shadow    <= '0;
            parity    <= 1'b0;
            cfg_q     <= CFG_RESET;
            cfg_vld_q <= 1'b0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            window    <= window_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            parity    <= parity_nxt;
            cfg_q     <= cfg_nxt;
            cfg_vld_q <= cfg_vld_nxt;
            cfg_err_q <= cfg_err_nxt;
            done_q    <= done_nxt;
        end
    end

    assign CFG       = cfg_q;
    assign CFG_VALID = cfg_vld_q;
    assign CFG_ERR   = cfg_err_q;
    assign DONE      = done_q;
    assign BUSY      = (state != IDLE);

endmodule
